// File: rtl/pool_pkg.sv
// pool_pkg: shared types, defaults and elaboration helpers for the pooling engine
package pool_pkg;
    typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_e;
    localparam int DATA_W_DEF = 16;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/avg_pool_stream_reduce.sv
// pool_lane_reduce: balanced sum/max tree across the lanes of one beat
module pool_lane_reduce
    import pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = 8,
    parameter int ACC_W  = DATA_W + 6
) (
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    mode_max,
    output logic signed [ACC_W-1:0] red
);
    // Sign-extend each lane, then fold pairs level by level down to one node
    always_comb begin
        logic signed [ACC_W-1:0] t [LANES];
        for (int k = 0; k < LANES; k++)
            t[k] = {{(ACC_W-DATA_W){in_data[k*DATA_W+DATA_W-1]}}, in_data[k*DATA_W +: DATA_W]};
        for (int s = LANES / 2; s > 0; s = s / 2)
            for (int i = 0; i < s; i++)
                t[i] = mode_max ? ((t[2*i] > t[2*i+1]) ? t[2*i] : t[2*i+1]) : t[2*i] + t[2*i+1];
        red = t[0];
    end
endmodule

// File: rtl/avg_pool_stream.sv
// avg_pool_stream: streaming average/max pooling over BEATS beats of LANES samples
module avg_pool_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = 8,
    parameter int BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    mode_max,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data
);
    localparam int SHIFT = clog2(LANES * BEATS);
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int BW    = clog2(BEATS);
    localparam int HALF  = 1 << (SHIFT - 1);

    if (!is_pow2(LANES) || LANES < 2) begin : g_bad_lanes
        $error("LANES must be a power of two and at least 2");
    end
    if (!is_pow2(BEATS) || BEATS < 2) begin : g_bad_beats
        $error("BEATS must be a power of two and at least 2");
    end

    logic [BW-1:0]           cnt;
    pool_mode_e              mode_q, cur_mode, s1_mode;
    logic                    hs, s1_v, s1_first, s1_last;
    logic signed [ACC_W-1:0] red, s1_val, acc, comb, rnd;
    logic [DATA_W-1:0]       res;

    assign in_ready = !(out_valid && !out_ready);
    assign hs       = in_valid && in_ready;
    assign cur_mode = (cnt == '0) ? pool_mode_e'(mode_max) : mode_q;

    pool_lane_reduce #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) u_reduce (
        .in_data (in_data),
        .mode_max(cur_mode == POOL_MAX),
        .red     (red)
    );

    // Beat counter and window mode, latched on the first beat of each window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mode_q <= POOL_AVG;
        end else if (flush) begin
            cnt    <= '0;
        end else if (hs) begin
            cnt    <= cnt + 1'b1;
            mode_q <= cur_mode;
        end
    end

    // Stage 1: register the lane reduction together with its window position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_val   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= POOL_AVG;
        end else begin
            s1_v <= hs && !flush;
            if (hs) begin
                s1_val   <= red;
                s1_first <= (cnt == '0);
                s1_last  <= (cnt == BW'(BEATS - 1));
                s1_mode  <= cur_mode;
            end
        end
    end

    // Fold the staged beat into the accumulator and form the rounded or max result
    always_comb begin
        comb = (s1_mode == POOL_MAX) ? ((s1_val > acc) ? s1_val : acc) : acc + s1_val;
        rnd  = comb + ACC_W'(HALF);
        res  = (s1_mode == POOL_MAX) ? comb[DATA_W-1:0] : DATA_W'(rnd >>> SHIFT);
    end

    // Stage 2: accumulator update; a new result wins over a simultaneous drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            acc       <= '0;
            if (out_ready) out_valid <= 1'b0;
        end else begin
            if (s1_v) acc <= s1_first ? s1_val : comb;
            if (s1_v && s1_last) begin
                out_valid <= 1'b1;
                out_data  <= res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_avg_pool_stream.sv
// tb_avg_pool_stream: directed checks of average/max pooling, stall, flush and reset
module tb_avg_pool_stream;
    localparam int D = 16;
    localparam int L = 8;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           rst_n, flush, mode_max, in_valid, in_ready, out_valid, out_ready;
    logic [L*D-1:0] in_data;
    logic [D-1:0]   out_data;
    logic [D-1:0]   got [$];
    int             errors = 0, checks = 0, cyc = 0;

    avg_pool_stream #(.DATA_W(D), .LANES(L), .BEATS(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .mode_max (mode_max),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) got.push_back(out_data);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [L*D-1:0] fill(input logic [D-1:0] v);
        logic [L*D-1:0] d;
        for (int k = 0; k < L; k++) d[k*D +: D] = v;
        return d;
    endfunction

    task automatic beat(input logic [L*D-1:0] d, input logic m);
        int w = 0;
        in_data  = d;
        mode_max = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("beat_stall", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [D-1:0] v, input logic m);
        for (int b = 0; b < B; b++) beat(fill(v), m);
    endtask

    task automatic expect_res(input string tag, input logic [D-1:0] exp);
        int w = 0;
        while (got.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (got.size() == 0) chk({tag, "_timeout"}, got.size(), 1);
        else chk(tag, got.pop_front(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [L*D-1:0] d;
        int c0, w;
        rst_n = 1'b0; flush = 1'b0; mode_max = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        window(16'h0001, 1'b0);
        in_valid = 1'b0;
        chk("t1_lat1", out_valid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat2", out_valid, 1);
        chk("t1_data", out_data, 16'h0001);
        expect_res("t1_ones", 16'h0001);

        c0 = cyc;
        window(16'h7FFF, 1'b0);
        window(16'h8000, 1'b0);
        in_valid = 1'b0;
        chk("t2_rate", cyc - c0, 2 * B);
        expect_res("t2_max_pos", 16'h7FFF);
        expect_res("t2_max_neg", 16'h8000);

        for (int b = 0; b < B; b++) begin
            d = fill(16'h0000);
            if (b == 0) d[D-1:0] = 16'd32;
            beat(d, 1'b0);
        end
        for (int b = 0; b < B; b++) begin
            d = fill(16'h0000);
            if (b == 0) d[D-1:0] = 16'hFFE0;
            beat(d, 1'b0);
        end
        in_valid = 1'b0;
        expect_res("t3_round_up", 16'h0001);
        expect_res("t3_round_neg", 16'h0000);

        for (int b = 0; b < B; b++) begin
            d = fill(16'hFFF0);
            if (b == 5) d[3*D +: D] = 16'h0123;
            beat(d, b < 4);
        end
        in_valid = 1'b0;
        expect_res("t4_max", 16'h0123);

        out_ready = 1'b0;
        window(16'h0002, 1'b0);
        in_data = fill(16'h0003);
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t5_in_ready", in_ready, 0);
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_data", out_data, 16'h0002);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int b = 0; b < B; b++) begin
            beat(fill(16'h0003), 1'b0);
            if (b == 0) chk("t5_drain", out_valid, 0);
        end
        in_valid = 1'b0;
        expect_res("t5_held", 16'h0002);
        expect_res("t5_next", 16'h0003);

        for (int b = 0; b < 3; b++) beat(fill(16'h0009), 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = fill(16'h0009);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        window(16'h0004, 1'b0);
        in_valid = 1'b0;
        expect_res("t6_flush", 16'h0004);

        out_ready = 1'b0;
        window(16'h0005, 1'b0);
        beat(fill(16'h0007), 1'b0);
        in_valid = 1'b0;
        chk("t7_pending", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        window(16'h0006, 1'b0);
        in_valid = 1'b0;
        expect_res("t7_after_rst", 16'h0006);
        repeat (4) @(posedge clk);
        #1;
        chk("no_extra_results", got.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
